// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer: reads up to two operands over one shared
// register-file read port and strobes them into the ALU input registers.
//
// Ports:
//   clock, reset         - single clock, synchronous active-high reset
//   run                  - CPU run enable; 0 freezes the CPU fetch path
//   req_valid/req_ready  - fetch request handshake from the decoder
//   req_{left,right}_en  - which operands to fetch
//   req_{left,right}_sel - source registers
//   rf_rd_sel/rf_rd_data - combinational register-file read port
//   left_load/right_load - input-register load strobes
//   op_done              - one-cycle pulse once the operands are latched
//   dbg_req/dbg_sel/dbg_ack/dbg_data - debug read port
//
// Build option: define OPSEQ_DEBUG_PORT_EN to add the debug read port.
// Without it the debug ports and the DBG state do not exist.
module operand_fetch_sequencer #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_left_en,
  input  logic              req_right_en,
  input  logic [SEL_W-1:0]  req_left_sel,
  input  logic [SEL_W-1:0]  req_right_sel,
  output logic [SEL_W-1:0]  rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              left_load,
  output logic              right_load,
`ifdef OPSEQ_DEBUG_PORT_EN
  output logic              op_done,
  input  logic              dbg_req,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
`else
  output logic              op_done
`endif
);

`ifdef OPSEQ_DEBUG_PORT_EN
  typedef enum logic [2:0] {
    IDLE, RD_LEFT, RD_RIGHT, DONE, DBG
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_LEFT, RD_RIGHT, DONE
  } state_t;
`endif

  state_t           state;
  logic [SEL_W-1:0] l_sel;
  logic [SEL_W-1:0] r_sel;
  logic             l_en;
  logic             r_en;
  logic             idle;
  logic             cpu_acc;

  assign idle = (state == IDLE);

`ifdef OPSEQ_DEBUG_PORT_EN
  logic last_dbg;
  logic cpu_pend;
  logic dbg_grant;

  // With both sides pending, whoever did not win last time wins now.
  assign cpu_pend  = idle && run && req_valid;
  assign dbg_grant = idle && dbg_req && !(cpu_pend && last_dbg);
  assign req_ready = idle && run && !dbg_grant && !reset;
`else
  assign req_ready = idle && run && !reset;
`endif

  assign cpu_acc = req_valid && req_ready;

  always_comb begin
    rf_rd_sel  = '0;
    left_load  = 1'b0;
    right_load = 1'b0;
    op_done    = 1'b0;
    unique case (state)
      RD_LEFT: begin
        rf_rd_sel = l_sel;
        left_load = run && l_en;
      end
      RD_RIGHT: begin
        rf_rd_sel  = r_sel;
        right_load = run && r_en;
      end
      DONE: op_done = run;
`ifdef OPSEQ_DEBUG_PORT_EN
      DBG: rf_rd_sel = dbg_sel;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      l_sel <= '0;
      r_sel <= '0;
      l_en  <= 1'b0;
      r_en  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
`ifdef OPSEQ_DEBUG_PORT_EN
          if (dbg_grant) state <= DBG;
          else
`endif
          if (cpu_acc) begin
            l_sel <= req_left_sel;
            r_sel <= req_right_sel;
            l_en  <= req_left_en;
            r_en  <= req_right_en;
            if (req_left_en)       state <= RD_LEFT;
            else if (req_right_en) state <= RD_RIGHT;
            else                   state <= DONE;
          end
        end
        RD_LEFT:  if (run) state <= r_en ? RD_RIGHT : DONE;
        RD_RIGHT: if (run) state <= DONE;
        DONE:     if (run) state <= IDLE;
`ifdef OPSEQ_DEBUG_PORT_EN
        DBG:      state <= IDLE;
`endif
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef OPSEQ_DEBUG_PORT_EN
  // Debug read completes in the cycle after DBG; data stays put
  // until the next debug read.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_dbg <= 1'b1;
      dbg_ack  <= 1'b0;
      dbg_data <= '0;
    end else begin
      dbg_ack <= (state == DBG);
      if (state == DBG) dbg_data <= rf_rd_data;
      if (dbg_grant)    last_dbg <= 1'b1;
      else if (cpu_acc) last_dbg <= 1'b0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^rf_rd_data;
`endif

endmodule

// File: doc/operand_fetch_sequencer.md
OPERAND_FETCH_SEQUENCER -- requirements
Module: operand_fetch_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width.
REQ-002 SHALL have parameter SEL_W, default 2, meaning register-select width (4 registers).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port run  input  1  CPU run enable; 0 freezes the CPU fetch path.
REQ-006 SHALL have port req_valid  input  1  decoder requests an operand fetch.
REQ-007 SHALL have port req_ready  output  1  sequencer accepts a request this cycle.
REQ-008 SHALL have port req_left_en  input  1  fetch the left operand.
REQ-009 SHALL have port req_right_en  input  1  fetch the right operand.
REQ-010 SHALL have port req_left_sel  input  SEL_W  left source register.
REQ-011 SHALL have port req_right_sel  input  SEL_W  right source register.
REQ-012 SHALL have port rf_rd_sel  output  SEL_W  register file read-port select (combinational read).
REQ-013 SHALL have port rf_rd_data  input  DATA_W  register file read data, valid in the same cycle as rf_rd_sel.
REQ-014 SHALL have port left_load  output  1  load strobe to the left input register.
REQ-015 SHALL have port right_load  output  1  load strobe to the right input register (c15).
REQ-016 SHALL have port op_done  output  1  one-cycle pulse; operands are latched.
REQ-017 SHALL have ports dbg_req in 1, dbg_sel in SEL_W, dbg_ack out 1, dbg_data out DATA_W (present only per REQ-036).

Function
REQ-018 SHALL implement states IDLE, RD_LEFT, RD_RIGHT, DONE, DBG.
REQ-019 SHALL drive req_ready=1 only in IDLE with run=1 and no debug grant that cycle.
REQ-020 SHALL accept a request on req_valid&&req_ready and register both selects and both enables.
REQ-021 On accept, next state SHALL be RD_LEFT if left_en; else RD_RIGHT if right_en; else DONE.
REQ-022 RD_LEFT SHALL drive rf_rd_sel=left_sel and left_load=1 for exactly one cycle, then go to RD_RIGHT if right_en, else DONE.
REQ-023 RD_RIGHT SHALL drive rf_rd_sel=right_sel and right_load=1 for exactly one cycle, then go to DONE.
REQ-024 DONE SHALL assert op_done for one cycle, then return to IDLE; req_ready SHALL be 0 in DONE.
REQ-025 Latency from accept to op_done SHALL be 3 cycles (both operands), 2 (one operand), 1 (neither).
REQ-026 left_load, right_load and op_done SHALL be Moore outputs decoded from state, gated by run.
REQ-027 While run=0 in RD_LEFT/RD_RIGHT/DONE, the state SHALL hold and all strobes SHALL be 0; the sequence resumes unchanged when run returns to 1.
REQ-028 In IDLE with no grant, rf_rd_sel SHALL be 0 and all strobes SHALL be 0.
REQ-029 When req_valid and dbg_req are both pending in IDLE with run=1, the grant SHALL alternate, using a last_grant flag (after reset the CPU wins first).
REQ-030 dbg_req alone in IDLE SHALL be granted regardless of run.
REQ-031 DBG SHALL last one cycle: drive rf_rd_sel=dbg_sel, register rf_rd_data into dbg_data, and pulse dbg_ack on the following cycle, then return to IDLE.
REQ-032 dbg_data SHALL hold its last value until the next debug read.
REQ-033 Changes on req_* inputs after accept SHALL NOT affect the operation in flight.

Reset
REQ-034 reset=1 at a clock edge SHALL force IDLE, last_grant=DEBUG, and all outputs to 0 (req_ready to 1 from the next cycle if run=1), aborting any operation without op_done.
REQ-035 reset SHALL take priority over run, req_valid and dbg_req.

Configuration
REQ-036 Macro OPSEQ_DEBUG_PORT_EN defined: debug ports and the DBG state SHALL exist per REQ-029..032. Not defined: the debug ports and DBG state SHALL be absent, and the CPU SHALL always win the grant.

Verification
REQ-037 Reset, then run=1, req left_sel=1, right_sel=2, both en: left_load in cycle +1 with sel=1, right_load in +2 with sel=2, op_done in +3.
REQ-038 Right-only request, sel=3: right_load at +1 with rf_rd_sel=3, op_done at +2, left_load never asserted.
REQ-039 run dropped for 4 cycles while in RD_RIGHT: no strobes during the freeze; right_load follows the first run=1 cycle, then op_done.
REQ-040 req_valid and dbg_req (sel=2, rf data 0xA5) held together: grants CPU, DBG, CPU, and dbg_data=0xA5 with dbg_ack pulsed once.
REQ-041 reset asserted in RD_LEFT: next cycle IDLE, all outputs 0, no op_done.
REQ-042 Build without OPSEQ_DEBUG_PORT_EN: back-to-back requests complete with a 1-cycle IDLE gap each.
